// File: rtl/frame_scanout.sv
// Frame-buffer scan-out: reads each 320x240 source pixel, writes it twice to the
// pixel FIFO and replays each line twice, producing a 640x480 stream.
//
//   state   | meaning
//   --------+------------------------------------------------
//   S_IDLE  | waiting for i_enable
//   S_ADDR  | o_fb_addr valid, frame buffer read in flight
//   S_LATCH | read data captured into r_pix
//   S_WR0   | first FIFO write of the pixel (stalls while full)
//   S_WR1   | second FIFO write, then advance x / rep / y
module frame_scanout #(
  parameter int H_SRC  = 320,
  parameter int V_SRC  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_fb_addr,
  input  logic [DATA_W-1:0] i_fb_data,
  input  logic              i_fifo_full,
  output logic              o_fifo_wr_en,
  output logic [DATA_W-1:0] o_fifo_din,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int XW = (H_SRC > 1) ? $clog2(H_SRC) : 1;
  localparam int YW = (V_SRC > 1) ? $clog2(V_SRC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_WR0, S_WR1} state_t;

  state_t            r_state;
  logic [XW-1:0]     r_src_x;
  logic [YW-1:0]     r_src_y;
  logic              r_rep;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [DATA_W-1:0] r_pix;
  logic              r_frame_done;

  logic w_last_x;
  logic w_last_y;
  logic w_writing;

  assign w_last_x  = (r_src_x == XW'(H_SRC - 1));
  assign w_last_y  = (r_src_y == YW'(V_SRC - 1));
  assign w_writing = (r_state == S_WR0) || (r_state == S_WR1);

  assign o_fifo_wr_en = w_writing && !i_fifo_full;
  assign o_fifo_din   = r_pix;
  assign o_fb_addr    = r_fb_addr;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_src_x      <= '0;
      r_src_y      <= '0;
      r_rep        <= 1'b0;
      r_row_base   <= '0;
      r_fb_addr    <= '0;
      r_pix        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_fb_addr <= r_row_base + ADDR_W'(r_src_x);
            r_state   <= S_ADDR;
          end
        end
        S_ADDR:  r_state <= S_LATCH;
        S_LATCH: begin
          r_pix   <= i_fb_data;
          r_state <= S_WR0;
        end
        S_WR0: begin
          if (!i_fifo_full) r_state <= S_WR1;
        end
        S_WR1: begin
          // The next read address is loaded together with the counters so it
          // is already valid when S_ADDR is entered.
          if (!i_fifo_full) begin
            r_state <= S_ADDR;
            if (!w_last_x) begin
              r_src_x   <= r_src_x + 1'b1;
              r_fb_addr <= r_row_base + ADDR_W'(r_src_x) + ADDR_W'(1);
            end else if (!r_rep) begin
              r_src_x   <= '0;
              r_rep     <= 1'b1;
              r_fb_addr <= r_row_base;
            end else if (!w_last_y) begin
              r_src_x    <= '0;
              r_rep      <= 1'b0;
              r_src_y    <= r_src_y + 1'b1;
              r_row_base <= r_row_base + ADDR_W'(H_SRC);
              r_fb_addr  <= r_row_base + ADDR_W'(H_SRC);
            end else begin
              r_src_x      <= '0;
              r_rep        <= 1'b0;
              r_src_y      <= '0;
              r_row_base   <= '0;
              r_fb_addr    <= '0;
              r_frame_done <= 1'b1;
              r_state      <= i_enable ? S_ADDR : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
